// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter.
//   state_e : arbiter FSM states
//   OP_*    : shifter op codes {sign_ext,dir}
//   SA_W, DST_W, OP_W : field widths of shift amount, destination tag, op code
package shift_arb_pkg;

  localparam int SA_W  = 5;
  localparam int DST_W = 5;
  localparam int OP_W  = 2;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRL = 2'b01;
  localparam logic [OP_W-1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Tag 0 marks a request that is consumed without producing a response.
  function automatic logic is_nop(input logic [DST_W-1:0] dst);
    return (dst == '0);
  endfunction

endpackage

// File: rtl/shift_arbiter_rr.sv
// Round-robin one-hot grant generator.
// The search starts at ptr_i and wraps modulo NREQ; the first asserted
// request wins.
//   req_i : request vector
//   ptr_i : highest-priority index for this cycle
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : binary index of the granted request
//   any_o : at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(ptr_i) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one serial shifter between NREQ requesters: round-robin grant,
// operand hold registers, shifter start sequencing and one tagged response
// channel with backpressure.
//
// Optional feature macro: SHIFT_ARB_ZERO_BYPASS_EN
//   defined   : sa==0 requests bypass the shifter, opB is returned directly.
//   undefined : sa==0 requests go through the shifter like any other.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   req_valid / req_ready  : per-requester handshake, req_ready one-hot
//   req_opB/sa/op/dst      : flattened per-requester operands, slice i
//   rsp_valid / rsp_ready  : response handshake
//   rsp_id/dst/result      : requester index, echoed tag, shifted value
//   sh_start, sh_opB/sa/op/dst : command to the shifter (from hold regs)
//   sh_stalled, sh_result  : shifter busy flag and result register
//
// state | meaning
// IDLE  | granting; req_ready is the combinational round-robin grant
// BUSY  | sh_start high, waiting for the cycle where sh_stalled is low
// RESP  | response held on rsp_* until rsp_ready
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_opB,
  input  logic [NREQ*SA_W-1:0]     req_sa,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*DST_W-1:0]    req_dst,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DST_W-1:0]         rsp_dst,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     sh_start,
  output logic [WIDTH-1:0]         sh_opB,
  output logic [SA_W-1:0]          sh_sa,
  output logic [OP_W-1:0]          sh_op,
  output logic [DST_W-1:0]         sh_dst,
  input  logic                     sh_stalled,
  input  logic [WIDTH-1:0]         sh_result
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [WIDTH-1:0] hold_opB_q;
  logic [SA_W-1:0]  hold_sa_q;
  logic [OP_W-1:0]  hold_op_q;
  logic [DST_W-1:0] hold_dst_q;
  logic [IDW-1:0]   hold_id_q;
  logic             sh_start_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [DST_W-1:0] rsp_dst_q;
  logic [WIDTH-1:0] rsp_result_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   win_idx;
  logic             any_req;
  logic [WIDTH-1:0] sel_opB;
  logic [SA_W-1:0]  sel_sa;
  logic [OP_W-1:0]  sel_op;
  logic [DST_W-1:0] sel_dst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  // Grants are only visible in IDLE so the response never overlaps a grant.
  assign req_ready = (state_q == IDLE) ? gnt : '0;

  always_comb begin
    sel_opB = req_opB[win_idx*WIDTH +: WIDTH];
    sel_sa  = req_sa[win_idx*SA_W +: SA_W];
    sel_op  = req_op[win_idx*OP_W +: OP_W];
    sel_dst = req_dst[win_idx*DST_W +: DST_W];
    ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      hold_opB_q   <= '0;
      hold_sa_q    <= '0;
      hold_op_q    <= '0;
      hold_dst_q   <= '0;
      hold_id_q    <= '0;
      sh_start_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_dst_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            hold_opB_q <= sel_opB;
            hold_sa_q  <= sel_sa;
            hold_op_q  <= sel_op;
            hold_dst_q <= sel_dst;
            hold_id_q  <= win_idx;
            ptr_q      <= ptr_d;
            if (!is_nop(sel_dst)) begin
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
              if (sel_sa == '0) begin
                rsp_result_q <= sel_opB;
                rsp_id_q     <= win_idx;
                rsp_dst_q    <= sel_dst;
                rsp_valid_q  <= 1'b1;
                state_q      <= RESP;
              end else begin
                sh_start_q <= 1'b1;
                state_q    <= BUSY;
              end
`else
              sh_start_q <= 1'b1;
              state_q    <= BUSY;
`endif
            end
          end
        end
        BUSY: begin
          // sh_stalled already covers the start cycle, so low means done;
          // start must drop now or the shifter would begin again.
          if (!sh_stalled) begin
            rsp_result_q <= sh_result;
            rsp_id_q     <= hold_id_q;
            rsp_dst_q    <= hold_dst_q;
            rsp_valid_q  <= 1'b1;
            sh_start_q   <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          sh_start_q  <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign sh_start   = sh_start_q;
  assign sh_opB     = hold_opB_q;
  assign sh_sa      = hold_sa_q;
  assign sh_op      = hold_op_q;
  assign sh_dst     = hold_dst_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_dst    = rsp_dst_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter with a behavioural serial shifter attached.
module tb_shift_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_opB;
  logic [NREQ*5-1:0]   req_sa;
  logic [NREQ*2-1:0]   req_op;
  logic [NREQ*5-1:0]   req_dst;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [4:0]          rsp_dst;
  logic [31:0]         rsp_result;
  logic                sh_start;
  logic [31:0]         sh_opB;
  logic [4:0]          sh_sa;
  logic [1:0]          sh_op;
  logic [4:0]          sh_dst;
  logic                sh_stalled;
  logic [31:0]         sh_result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int gnt_q[$];

  shift_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opB    (req_opB),
    .req_sa     (req_sa),
    .req_op     (req_op),
    .req_dst    (req_dst),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_dst    (rsp_dst),
    .rsp_result (rsp_result),
    .sh_start   (sh_start),
    .sh_opB     (sh_opB),
    .sh_sa      (sh_sa),
    .sh_op      (sh_op),
    .sh_dst     (sh_dst),
    .sh_stalled (sh_stalled),
    .sh_result  (sh_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f_shift(input logic [31:0] a, input logic [4:0] s,
                                          input logic [1:0] op);
    case (op)
      2'b01:   return a >> s;
      2'b11:   return 32'($signed(a) >>> s);
      default: return a << s;
    endcase
  endfunction

  // Serial shifter: sa+2 cycles from start, stalled low in the last one.
  logic        shm_busy;
  logic [4:0]  shm_cnt;
  logic [31:0] shm_res;
  assign sh_stalled = (sh_start && !shm_busy) || (shm_busy && shm_cnt != 5'd0);
  assign sh_result  = shm_res;
  always @(posedge clk) begin
    if (reset) begin
      shm_busy <= 1'b0;
      shm_cnt  <= '0;
      shm_res  <= '0;
    end else if (!shm_busy) begin
      if (sh_start) begin
        shm_busy <= 1'b1;
        shm_cnt  <= sh_sa;
        shm_res  <= f_shift(sh_opB, sh_sa, sh_op);
      end
    end else if (shm_cnt != 5'd0) begin
      shm_cnt <= shm_cnt - 5'd1;
    end else begin
      shm_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level expectation: mode 0 granting, 1 shifting, 2 responding.
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          m_ptr  = 0;
  int          m_id   = 0;
  logic [31:0] m_opB  = '0;
  logic [4:0]  m_sa   = '0;
  logic [1:0]  m_op   = '0;
  logic [4:0]  m_dst  = '0;
  logic [31:0] m_res  = '0;

  always @(negedge clk) begin
    int w;
    int c;
    logic [NREQ-1:0] exp_rdy;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[c]) w = c;
    end
    exp_rdy = '0;
    if (m_mode == 0 && w >= 0) exp_rdy[w] = 1'b1;
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("onehot", 64'($countones(req_ready) <= 1), 64'd1);
      check("sh_start", 64'(sh_start), 64'(m_mode == 1));
      check("rsp_valid", 64'(rsp_valid), 64'(m_mode == 2));
      if (m_mode == 1) begin
        check("sh_opB", 64'(sh_opB), 64'(m_opB));
        check("sh_sa", 64'(sh_sa), 64'(m_sa));
        check("sh_op", 64'(sh_op), 64'(m_op));
        check("sh_dst", 64'(sh_dst), 64'(m_dst));
      end
      if (m_mode == 2) begin
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_dst", 64'(rsp_dst), 64'(m_dst));
        check("rsp_result", 64'(rsp_result), 64'(m_res));
      end
    end
    if (!reset && (req_valid & req_ready) != '0)
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) gnt_q.push_back(k);
    if (reset) begin
      m_mode = 0;
      m_ptr  = 0;
    end else begin
      case (m_mode)
        0: if (w >= 0) begin
          m_ptr = (w + 1) % NREQ;
          if (req_dst[w*5 +: 5] != 5'd0) begin
            m_id  = w;
            m_opB = req_opB[w*32 +: 32];
            m_sa  = req_sa[w*5 +: 5];
            m_op  = req_op[w*2 +: 2];
            m_dst = req_dst[w*5 +: 5];
            m_res = f_shift(m_opB, m_sa, m_op);
            m_mode = 1;
            m_cnt  = int'(m_sa) + 2;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
            if (m_sa == 5'd0) begin
              m_res  = m_opB;
              m_mode = 2;
            end
`endif
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_mode = 2;
        end
        default: if (rsp_ready) m_mode = 0;
      endcase
    end
  end

  task automatic set_req(input int i, input logic [31:0] opB, input logic [4:0] sa,
                         input logic [1:0] op, input logic [4:0] dst);
    req_opB[i*32 +: 32] = opB;
    req_sa[i*5 +: 5]    = sa;
    req_op[i*2 +: 2]    = op;
    req_dst[i*5 +: 5]   = dst;
  endtask

  task automatic issue(input int i, input logic [31:0] opB, input logic [4:0] sa,
                       input logic [1:0] op, input logic [4:0] dst, output int g);
    @(posedge clk); #1;
    set_req(i, opB, sa, op, dst);
    req_valid[i] = 1'b1;
    g = -1;
    for (int t = 0; t < 60 && g < 0; t++) begin
      @(negedge clk);
      if (req_ready[i]) g = cyc;
    end
    if (g < 0) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int r);
    r = -1;
    for (int t = 0; t < 100 && r < 0; t++) begin
      @(negedge clk);
      if (rsp_valid) r = cyc;
    end
    if (r < 0) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, bad, lat0;
    int rr_exp[5];
    logic [31:0] snap;
    rr_exp = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req_valid = '0;
    req_opB = '0;
    req_sa = '0;
    req_op = '0;
    req_dst = '0;
    rsp_ready = 1'b1;

    // All four requesters valid from reset: grants rotate 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 5'd1, 2'b00, 5'(i + 1));
    req_valid = 4'hF;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_sh_start", 64'(sh_start), 64'd0);
    check("reset_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 300 && gnt_q.size() < 5; t++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 5; k++)
      check("rr_order", 64'((k < gnt_q.size()) ? gnt_q[k] : -1), 64'(rr_exp[k]));
    repeat (12) @(posedge clk);

    // SLL 1 by 4.
    issue(0, 32'h0000_0001, 5'd4, 2'b00, 5'd3, g);
    wait_rsp(r);
    check("t1_latency", 64'(r - g), 64'd7);
    check("t1_result", 64'(rsp_result), 64'h10);
    check("t1_id", 64'(rsp_id), 64'd0);
    check("t1_dst", 64'(rsp_dst), 64'd3);

    // SRA / SRL of the sign bit by 31.
    issue(1, 32'h8000_0000, 5'd31, 2'b11, 5'd7, g);
    wait_rsp(r);
    check("t2_sra_latency", 64'(r - g), 64'd34);
    check("t2_sra_result", 64'(rsp_result), 64'hFFFF_FFFF);
    check("t2_sra_id", 64'(rsp_id), 64'd1);
    issue(1, 32'h8000_0000, 5'd31, 2'b01, 5'd7, g);
    wait_rsp(r);
    check("t2_srl_result", 64'(rsp_result), 64'h1);

    // Nop on requester 3 (pointer is 2), real request on 0 granted next cycle.
    @(posedge clk); #1;
    set_req(3, 32'h1234, 5'd2, 2'b00, 5'd0);
    set_req(0, 32'h3, 5'd1, 2'b00, 5'd9);
    req_valid = 4'b1001;
    g = -1;
    for (int t = 0; t < 20 && g < 0; t++) begin
      @(negedge clk);
      if (req_ready[3]) g = cyc;
    end
    check("t5_nop_grant", 64'(g >= 0), 64'd1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(negedge clk);
    check("t5_next_grant", 64'(req_ready), 64'b0001);
    check("t5_next_cycle", 64'(cyc - g), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(r);
    check("t5_rsp_dst", 64'(rsp_dst), 64'd9);
    check("t5_rsp_result", 64'(rsp_result), 64'h6);

    // sa == 0.
    issue(2, 32'hDEAD_BEEF, 5'd0, 2'b00, 5'd5, g);
    wait_rsp(r);
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
    lat0 = 1;
`else
    lat0 = 3;
`endif
    check("t4_latency", 64'(r - g), 64'(lat0));
    check("t4_result", 64'(rsp_result), 64'hDEAD_BEEF);
    check("t4_id", 64'(rsp_id), 64'd2);

    // Backpressure: response held for 10 cycles, pending request not granted.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1, 32'h0000_00F0, 5'd4, 2'b01, 5'd12, g);
    set_req(2, 32'h0, 5'd1, 2'b00, 5'd0);
    req_valid[2] = 1'b1;
    wait_rsp(r);
    check("t6_result", 64'(rsp_result), 64'hF);
    snap = rsp_result;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== snap || rsp_dst !== 5'd12 ||
          req_ready !== 4'b0000) bad++;
    end
    check("t6_stall_stable", 64'(bad), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_no_overlap", 64'(req_ready), 64'b0000);
    @(negedge clk);
    check("t6_grant_after", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;

    // Reset in the middle of a long shift abandons it.
    issue(3, 32'h1, 5'd20, 2'b00, 5'd4, g);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_reset_sh_start", 64'(sh_start), 64'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    check("t6_reset_no_rsp", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
